nor_bus_ctrl: RTL and testbench

Wishbone (pipelined) slave that turns single-word read/write requests from the QSPI control FSM into timed asynchronous parallel-NOR bus cycles (CE#/OE#/WE#, address, 16-bit DQ). It sits directly downstream of the QSPI command FSM and drives the NOR device pins. Access timing is set by cycle-count parameters. The device RY/BY# line gates the start of every new bus cycle.

---
 rtl/nor_bus_ctrl_pkg.sv | 29 ++
 rtl/nor_bus_ctrl_sync2_arst.sv | 24 ++
 rtl/nor_bus_ctrl.sv | 152 +++++++++++++++
 tb/tb_nor_bus_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/nor_bus_ctrl_pkg.sv
// Shared definitions for the NOR bus controller: FSM state encodings and
// default access timing in clock cycles.
package nor_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    NOR_ST_IDLE   = 2'd0,
    NOR_ST_SETUP  = 2'd1,
    NOR_ST_ACCESS = 2'd2,
    NOR_ST_HOLD   = 2'd3
  } nor_state_t;

  localparam int NOR_ADDRBITS_DEF     = 26;
  localparam int NOR_DATABITS_DEF     = 16;
  localparam int NOR_TSETUP_DEF       = 2;
  localparam int NOR_TRD_DEF          = 12;
  localparam int NOR_TWR_DEF          = 6;
  localparam int NOR_THOLD_DEF        = 2;
  localparam int NOR_BUSY_TIMEOUT_DEF = 65535;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/nor_bus_ctrl_sync2_arst.sv
// Two-flop synchroniser with asynchronous active-low reset and a
// selectable reset value.
module sync2_arst #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nor_bus_ctrl.sv
// Pipelined Wishbone slave generating timed async parallel-NOR read/write cycles.
// Optional RY/BY# wait timeout is enabled by defining NOR_BUSY_TIMEOUT_EN.
module nor_bus_ctrl
  import nor_bus_ctrl_pkg::*;
#(
  parameter int ADDRBITS     = NOR_ADDRBITS_DEF,
  parameter int DATABITS     = NOR_DATABITS_DEF,
  parameter int TSETUP       = NOR_TSETUP_DEF,
  parameter int TRD          = NOR_TRD_DEF,
  parameter int TWR          = NOR_TWR_DEF,
  parameter int THOLD        = NOR_THOLD_DEF,
  parameter int BUSY_TIMEOUT = NOR_BUSY_TIMEOUT_DEF
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [ADDRBITS-1:0] wb_adr_i,
  input  logic [DATABITS-1:0] wb_dat_i,
  output logic [DATABITS-1:0] wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_stall_o,
  output logic                wb_err_o,
  output logic [ADDRBITS-1:0] nor_addr_o,
  output logic [DATABITS-1:0] nor_dq_o,
  input  logic [DATABITS-1:0] nor_dq_i,
  output logic                nor_dq_oe_o,
  output logic                nor_ce_n_o,
  output logic                nor_oe_n_o,
  output logic                nor_we_n_o,
  input  logic                nor_ryby_i
);

  localparam int CNT_MAX = max4(TSETUP, TRD, TWR, THOLD);
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  if (TSETUP < 1 || TRD < 1 || TWR < 1 || THOLD < 1 || BUSY_TIMEOUT < 1) begin : g_param_check
    $error("nor_bus_ctrl: timing parameters must all be >= 1");
  end

  nor_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             ryby_s;
  logic             we_lat;
  logic             live;
  logic             accept;

  sync2_arst #(.RST_VAL(1'b0)) u_ryby_sync (
    .clk   (clk_i),
    .rst_n (reset_ni),
    .d     (nor_ryby_i),
    .q     (ryby_s)
  );

  assign wb_stall_o = (state != NOR_ST_IDLE) || !ryby_s;
  assign accept     = (state == NOR_ST_IDLE) && wb_cyc_i && wb_stb_i && !wb_stall_o;
  assign cnt_zero   = (cnt == '0);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state <= NOR_ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      NOR_ST_IDLE:   if (accept)   state_nxt = NOR_ST_SETUP;
      NOR_ST_SETUP:  if (cnt_zero) state_nxt = NOR_ST_ACCESS;
      NOR_ST_ACCESS: if (cnt_zero) state_nxt = NOR_ST_HOLD;
      NOR_ST_HOLD:   if (cnt_zero) state_nxt = NOR_ST_IDLE;
      default:                     state_nxt = NOR_ST_IDLE;
    endcase
  end

  // Strobes decode straight from the state register so reset deasserts them at once.
  always_comb begin
    nor_ce_n_o  = (state == NOR_ST_IDLE);
    nor_oe_n_o  = !((state == NOR_ST_ACCESS) && !we_lat);
    nor_we_n_o  = !((state == NOR_ST_ACCESS) && we_lat);
    nor_dq_oe_o = (state != NOR_ST_IDLE) && we_lat;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt        <= '0;
      we_lat     <= 1'b0;
      live       <= 1'b0;
      nor_addr_o <= '0;
      nor_dq_o   <= '0;
      wb_dat_o   <= '0;
      wb_ack_o   <= 1'b0;
    end else begin
      wb_ack_o <= 1'b0;
      if (state != state_nxt) begin
        case (state_nxt)
          NOR_ST_SETUP:  cnt <= CNT_W'(TSETUP - 1);
          NOR_ST_ACCESS: cnt <= we_lat ? CNT_W'(TWR - 1) : CNT_W'(TRD - 1);
          NOR_ST_HOLD:   cnt <= CNT_W'(THOLD - 1);
          default:       cnt <= '0;
        endcase
      end else if (!cnt_zero) begin
        cnt <= cnt - 1'b1;
      end

      // An abandoned cycle still runs to completion; only the ack is withheld.
      if (accept) begin
        we_lat     <= wb_we_i;
        live       <= 1'b1;
        nor_addr_o <= wb_adr_i;
        nor_dq_o   <= wb_dat_i;
      end else if (!wb_cyc_i) begin
        live <= 1'b0;
      end

      if ((state == NOR_ST_ACCESS) && cnt_zero) begin
        wb_ack_o <= live && wb_cyc_i;
        if (!we_lat) wb_dat_o <= nor_dq_i;
      end
    end
  end

`ifdef NOR_BUSY_TIMEOUT_EN
  logic [15:0] bto_cnt;
  logic        bto_run;
  logic        err_q;

  assign bto_run  = (state == NOR_ST_IDLE) && wb_cyc_i && wb_stb_i && !ryby_s;
  assign wb_err_o = err_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      bto_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (!bto_run) begin
        bto_cnt <= '0;
      end else if (bto_cnt == 16'(BUSY_TIMEOUT - 1)) begin
        bto_cnt <= '0;
        err_q   <= 1'b1;
      end else begin
        bto_cnt <= bto_cnt + 16'd1;
      end
    end
  end
`else
  assign wb_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_nor_bus_ctrl.sv
// Directed bench for nor_bus_ctrl with default timing (TSETUP=2, TRD=12,
// TWR=6, THOLD=2); outputs are sampled on the falling clock edge.
module tb_nor_bus_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [25:0] wb_adr_i;
  logic [15:0] wb_dat_i, wb_dat_o;
  logic        wb_ack_o, wb_stall_o, wb_err_o;
  logic [25:0] nor_addr_o;
  logic [15:0] nor_dq_o, nor_dq_i;
  logic        nor_dq_oe_o, nor_ce_n_o, nor_oe_n_o, nor_we_n_o, nor_ryby_i;

  int compared   = 0;
  int mismatched = 0;

  int          ce_low, oe_low, we_low, ack_at, ack_cnt, addr_bad, dq_bad, busy_bad;
  logic [15:0] dat_at_ack;

  always #5 clk_i = ~clk_i;

  nor_bus_ctrl dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .wb_cyc_i    (wb_cyc_i),
    .wb_stb_i    (wb_stb_i),
    .wb_we_i     (wb_we_i),
    .wb_adr_i    (wb_adr_i),
    .wb_dat_i    (wb_dat_i),
    .wb_dat_o    (wb_dat_o),
    .wb_ack_o    (wb_ack_o),
    .wb_stall_o  (wb_stall_o),
    .wb_err_o    (wb_err_o),
    .nor_addr_o  (nor_addr_o),
    .nor_dq_o    (nor_dq_o),
    .nor_dq_i    (nor_dq_i),
    .nor_dq_oe_o (nor_dq_oe_o),
    .nor_ce_n_o  (nor_ce_n_o),
    .nor_oe_n_o  (nor_oe_n_o),
    .nor_we_n_o  (nor_we_n_o),
    .nor_ryby_i  (nor_ryby_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs n cycles after an accept edge, collecting pin activity; stb drops
  // in the first cycle and cyc drops at cycle drop_at when nonzero.
  task automatic observe(input int n, input int drop_at, input logic wr,
                         input logic [25:0] exp_addr, input logic [15:0] exp_dq);
    ce_low = 0; oe_low = 0; we_low = 0; ack_at = -1; ack_cnt = 0;
    addr_bad = 0; dq_bad = 0; dat_at_ack = '0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk_i);
      if (k == 1) wb_stb_i = 1'b0;
      if (k == drop_at) wb_cyc_i = 1'b0;
      if (!nor_ce_n_o) begin
        ce_low++;
        if (nor_addr_o !== exp_addr) addr_bad++;
        if (wr ? (!nor_dq_oe_o || nor_dq_o !== exp_dq) : nor_dq_oe_o) dq_bad++;
      end
      if (!nor_oe_n_o) oe_low++;
      if (!nor_we_n_o) we_low++;
      if (wb_ack_o) begin
        ack_cnt++;
        if (ack_at < 0) begin
          ack_at     = k;
          dat_at_ack = wb_dat_o;
        end
      end
    end
  endtask

  initial begin
    reset_ni = 1'b1; nor_ryby_i = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; nor_dq_i = '0;
    #2 reset_ni = 1'b0;
    repeat (3) @(negedge clk_i);

    chk("rst_ce_n",  32'(nor_ce_n_o),  32'd1);
    chk("rst_oe_n",  32'(nor_oe_n_o),  32'd1);
    chk("rst_we_n",  32'(nor_we_n_o),  32'd1);
    chk("rst_dq_oe", 32'(nor_dq_oe_o), 32'd0);
    chk("rst_ack",   32'(wb_ack_o),    32'd0);
    chk("rst_addr",  32'(nor_addr_o),  32'd0);
    chk("rst_dat_o", 32'(wb_dat_o),    32'd0);
    chk("rst_stall", 32'(wb_stall_o),  32'd1);

    reset_ni = 1'b1;
    @(negedge clk_i);
    chk("stall_rel_1", 32'(wb_stall_o), 32'd1);
    @(negedge clk_i);
    chk("stall_rel_2", 32'(wb_stall_o), 32'd0);

    // Read at defaults: ack on cycle 15, CE# low 16, OE# low 12.
    nor_dq_i = 16'hA5C3;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 26'h1234567;
    observe(20, 0, 1'b0, 26'h1234567, 16'h0);
    chk("rd_ce_low",   32'(ce_low),     32'd16);
    chk("rd_oe_low",   32'(oe_low),     32'd12);
    chk("rd_we_low",   32'(we_low),     32'd0);
    chk("rd_ack_at",   32'(ack_at),     32'd15);
    chk("rd_ack_cnt",  32'(ack_cnt),    32'd1);
    chk("rd_data",     32'(dat_at_ack), 32'hA5C3);
    chk("rd_addr_bad", 32'(addr_bad),   32'd0);
    chk("rd_dq_oe",    32'(dq_bad),     32'd0);
    chk("rd_stall_end", 32'(wb_stall_o), 32'd0);
    wb_cyc_i = 1'b0;
    @(negedge clk_i);

    // Write: ack on cycle 9, WE# low 6, DQ driven across CE# low; read data untouched.
    nor_dq_i = 16'hFFFF;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 26'h0000555; wb_dat_i = 16'h00AA;
    observe(14, 0, 1'b1, 26'h0000555, 16'h00AA);
    chk("wr_ce_low",   32'(ce_low),   32'd10);
    chk("wr_we_low",   32'(we_low),   32'd6);
    chk("wr_oe_low",   32'(oe_low),   32'd0);
    chk("wr_ack_at",   32'(ack_at),   32'd9);
    chk("wr_ack_cnt",  32'(ack_cnt),  32'd1);
    chk("wr_dq_bad",   32'(dq_bad),   32'd0);
    chk("wr_addr_bad", 32'(addr_bad), 32'd0);
    chk("wr_dat_o",    32'(wb_dat_o), 32'hA5C3);
    wb_cyc_i = 1'b0;
    @(negedge clk_i);

    // Device busy: request held 40 cycles with no NOR activity, then accepted
    // on the edge after the synchronised RY/BY# releases stall.
    nor_ryby_i = 1'b0;
    repeat (2) @(negedge clk_i);
    nor_dq_i = 16'h1357;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 26'h0ABCDEF;
    busy_bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (!wb_stall_o || !nor_ce_n_o) busy_bad++;
    end
    chk("busy_hold", 32'(busy_bad), 32'd0);
    nor_ryby_i = 1'b1;
    @(negedge clk_i);
    chk("busy_rise_1", 32'(wb_stall_o), 32'd1);
    @(negedge clk_i);
    chk("busy_rise_2", 32'(wb_stall_o), 32'd0);
    chk("busy_ce_idle", 32'(nor_ce_n_o), 32'd1);
    observe(20, 0, 1'b0, 26'h0ABCDEF, 16'h0);
    chk("busy_ce_low", 32'(ce_low),     32'd16);
    chk("busy_ack_at", 32'(ack_at),     32'd15);
    chk("busy_data",   32'(dat_at_ack), 32'h1357);
    wb_cyc_i = 1'b0;
    @(negedge clk_i);

    // cyc dropped in the 3rd ACCESS cycle: strobe runs full length, no ack.
    nor_dq_i = 16'h0F0F;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 26'h3FFFFFF;
    observe(22, 5, 1'b0, 26'h3FFFFFF, 16'h0);
    chk("abort_oe_low",  32'(oe_low),     32'd12);
    chk("abort_ce_low",  32'(ce_low),     32'd16);
    chk("abort_ack_cnt", 32'(ack_cnt),    32'd0);
    chk("abort_stall",   32'(wb_stall_o), 32'd0);
    chk("abort_addr",    32'(addr_bad),   32'd0);

    // Async reset during the write strobe.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 26'h2AAAAAA; wb_dat_i = 16'h5555;
    @(negedge clk_i);
    wb_stb_i = 1'b0;
    repeat (4) @(negedge clk_i);
    chk("arst_we_pre", 32'(nor_we_n_o), 32'd0);
    reset_ni = 1'b0;
    #1;
    chk("arst_we_n",  32'(nor_we_n_o),  32'd1);
    chk("arst_ce_n",  32'(nor_ce_n_o),  32'd1);
    chk("arst_dq_oe", 32'(nor_dq_oe_o), 32'd0);
    chk("arst_dat_o", 32'(wb_dat_o),    32'd0);
    wb_cyc_i = 1'b0;
    @(negedge clk_i);
    reset_ni = 1'b1;
    @(negedge clk_i);
    chk("arst_stall_1", 32'(wb_stall_o), 32'd1);
    @(negedge clk_i);
    chk("arst_stall_2", 32'(wb_stall_o), 32'd0);
    chk("err_idle",     32'(wb_err_o),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
